// File: rtl/hc_sr04_echo_emulator_if.sv
// hc_sr04_echo_emulator_if: trig/echo link between a ranging controller and the sensor emulator
interface hc_sr04_echo_emulator_if;
    logic        trig;
    logic [11:0] distance_mm;
    logic        echo;
    logic        busy;
    logic        trig_err;
    modport master (output trig, distance_mm, input echo, busy, trig_err);
    modport slave  (input trig, distance_mm, output echo, busy, trig_err);
endinterface

// File: rtl/hc_sr04_echo_emulator.sv
// hc_sr04_echo_emulator: answers a valid trig pulse with an echo pulse whose width encodes distance_mm
module hc_sr04_echo_emulator #(
    parameter int unsigned TRIG_MIN_CYC    = 500,
    parameter int unsigned BURST_DELAY_CYC = 25000,
    parameter int unsigned CYC_PER_MM      = 294,
    parameter int unsigned MAX_MM          = 4000,
    parameter int unsigned TIMEOUT_CYC     = 1900000,
    parameter int unsigned HOLDOFF_CYC     = 500000
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    hc_sr04_echo_emulator_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG_HI = 3'd1;
    localparam logic [2:0] DELAY   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d, width;
    logic [11:0] mm_q, mm_d;
    logic [2:0]  sync_q, sync_d;
    logic        echo_q, echo_d, busy_q, busy_d, trig_err_q, trig_err_d;
    logic        rise, fall;

    // sync_q[1] is the synchronized trig, sync_q[2] its registered copy for edge detection
    assign sync_d = {sync_q[1:0], bus.trig};
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];
    assign width  = (mm_q == 12'd0 || {20'd0, mm_q} > MAX_MM) ? TIMEOUT_CYC : {20'd0, mm_q} * CYC_PER_MM;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mm_d       = mm_q;
        echo_d     = echo_q;
        busy_d     = busy_q;
        trig_err_d = 1'b0;
        case (state_q)
            IDLE: if (rise) begin
                state_d = TRIG_HI;
                cnt_d   = 32'd1;
            end
            TRIG_HI: if (fall) begin
                state_d    = (cnt_q >= TRIG_MIN_CYC) ? DELAY : IDLE;
                busy_d     = cnt_q >= TRIG_MIN_CYC;
                trig_err_d = cnt_q < TRIG_MIN_CYC;
                mm_d       = (cnt_q >= TRIG_MIN_CYC) ? bus.distance_mm : mm_q;
                cnt_d      = 32'd0;
            end else if (cnt_q < TRIG_MIN_CYC) begin
                cnt_d = cnt_q + 32'd1;
            end
            DELAY: if (cnt_q == BURST_DELAY_CYC) begin
                state_d = ECHO;
                echo_d  = 1'b1;
                cnt_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            ECHO: if (cnt_q == width - 32'd1) begin
                state_d = HOLDOFF;
                echo_d  = 1'b0;
                cnt_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            HOLDOFF: if (cnt_q == HOLDOFF_CYC - 32'd1) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            cnt_q      <= 32'd0;
            mm_q       <= 12'd0;
            sync_q     <= 3'd0;
            echo_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mm_q       <= mm_d;
            sync_q     <= sync_d;
            echo_q     <= echo_d;
            busy_q     <= busy_d;
            trig_err_q <= trig_err_d;
        end
    end

    assign bus.echo     = echo_q;
    assign bus.busy     = busy_q;
    assign bus.trig_err = trig_err_q;
endmodule

// File: tb/tb_hc_sr04_echo_emulator.sv
// tb_hc_sr04_echo_emulator: pin-level reference model feeds a scoreboard; a negedge monitor checks the DUT
module tb_hc_sr04_echo_emulator;
    localparam int TMIN = 10, BD = 20, CPM = 2, MAXMM = 400, TO = 1000, HO = 30;

    typedef struct {int busy_rise; int echo_rise; int width;} exp_t;

    logic sys_clk, sys_rst;
    hc_sr04_echo_emulator_if bus();

    hc_sr04_echo_emulator #(
        .TRIG_MIN_CYC(TMIN), .BURST_DELAY_CYC(BD), .CYC_PER_MM(CPM),
        .MAX_MM(MAXMM), .TIMEOUT_CYC(TO), .HOLDOFF_CYC(HO)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int   cyc = 0, free_at = 0, run_a = 0, n_acc = 0, n_echo = 0, rise_cyc = 0;
    int   n_checks = 0, n_err = 0;
    logic m_prev = 1'b0, m_ok = 1'b0, pe = 1'b0, pb = 1'b0, have_cur = 1'b0;
    exp_t exp_q[$];
    int   err_q[$];
    exp_t cur;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input int act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0d, expected no such event (cycle %0d)", name, act, cyc);
    endtask

    function automatic int echo_width(input int mm);
        return (mm == 0 || mm > MAXMM) ? TO : mm * CPM;
    endfunction

    // Reference model: pin samples at each clock edge grouped into high runs; a run that starts
    // while the sensor is idle becomes an echo (long enough) or a trig_err (too short).
    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (sys_rst) begin
            m_prev  = 1'b0;
            m_ok    = 1'b0;
            free_at = 0;
            exp_q.delete();
            err_q.delete();
        end else begin
            if (bus.trig && !m_prev) begin
                run_a = cyc;
                m_ok  = free_at <= cyc + 1;
            end
            if (!bus.trig && m_prev && m_ok) begin
                if (cyc - run_a >= TMIN) begin
                    exp_t e;
                    e.busy_rise = cyc + 2;
                    e.echo_rise = cyc + 3 + BD;
                    e.width     = echo_width(int'(bus.distance_mm));
                    exp_q.push_back(e);
                    free_at = e.echo_rise + e.width + HO;
                    n_acc++;
                end else begin
                    err_q.push_back(cyc + 2);
                end
            end
            m_prev = bus.trig;
        end
    end

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            have_cur = 1'b0;
            pe = 1'b0;
            pb = 1'b0;
        end else begin
            if (bus.trig_err) begin
                if (err_q.size() == 0) flag("trig_err_unexpected", 1);
                else check("trig_err_cycle", cyc, err_q.pop_front());
            end
            if (bus.busy && !pb) begin
                if (have_cur || exp_q.size() == 0) flag("busy_rise_unexpected", cyc);
                else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    check("busy_rise_cycle", cyc, cur.busy_rise);
                end
            end
            if (bus.echo && !bus.busy) flag("echo_without_busy", 1);
            if (bus.echo && !pe) begin
                n_echo++;
                rise_cyc = cyc;
                if (!have_cur) flag("echo_rise_unexpected", cyc);
                else check("echo_rise_cycle", cyc, cur.echo_rise);
            end
            if (!bus.echo && pe && have_cur) check("echo_width", cyc - rise_cyc, cur.width);
            if (!bus.busy && pb) begin
                if (!have_cur) flag("busy_fall_unexpected", cyc);
                else check("busy_fall_cycle", cyc, cur.echo_rise + cur.width + HO);
                have_cur = 1'b0;
            end
            pe = bus.echo;
            pb = bus.busy;
        end
    end

    task automatic pulse(input int n);
        @(negedge sys_clk) bus.trig = 1'b1;
        repeat (n) @(negedge sys_clk);
        bus.trig = 1'b0;
    endtask

    task automatic wait_echo(input logic v);
        int n = 0;
        while (bus.echo !== v && n < 3000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 3000) flag("wait_echo_timeout", int'(v));
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge sys_clk);
        while ((cyc <= free_at || exp_q.size() != 0 || err_q.size() != 0 || have_cur) && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 4000) flag("wait_idle_timeout", n);
    endtask

    initial begin
        int dists[3] = '{401, 0, 400};
        int n0;
        sys_rst = 1'b1;
        bus.trig = 1'b0;
        bus.distance_mm = 12'd0;
        repeat (3) @(negedge sys_clk);
        check("reset_echo", int'(bus.echo), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_trig_err", int'(bus.trig_err), 0);
        sys_rst = 1'b0;

        bus.distance_mm = 12'd100;
        pulse(15);
        wait_idle();
        pulse(5);
        wait_idle();
        pulse(12);
        wait_idle();
        pulse(TMIN - 1);
        wait_idle();
        pulse(TMIN);
        wait_idle();
        foreach (dists[i]) begin
            bus.distance_mm = 12'(dists[i]);
            pulse(15);
            wait_idle();
        end

        bus.distance_mm = 12'd100;
        pulse(15);
        wait_echo(1'b1);
        repeat (20) @(negedge sys_clk);
        pulse(15);
        bus.distance_mm = 12'd50;
        wait_echo(1'b0);
        pulse(15);
        wait_idle();

        bus.distance_mm = 12'd100;
        pulse(15);
        wait_echo(1'b1);
        wait_echo(1'b0);
        repeat (20) @(negedge sys_clk);
        bus.trig = 1'b1;
        repeat (30) @(negedge sys_clk);
        bus.trig = 1'b0;
        wait_idle();

        pulse(15);
        wait_echo(1'b1);
        repeat (50) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("rst_echo_drop", int'(bus.echo), 0);
        check("rst_busy_drop", int'(bus.busy), 0);
        @(negedge sys_clk) sys_rst = 1'b0;
        n0 = n_echo;
        repeat (300) @(negedge sys_clk);
        check("no_echo_after_reset", n_echo, n0);

        bus.distance_mm = 12'($urandom_range(0, 450));
        for (int i = 0; i < 20; i++) begin
            #($urandom_range(0, 130));
            if ($time % 10 == 5) #1;
            bus.trig = ~bus.trig;
        end
        if ($time % 10 == 5) #1;
        bus.trig = 1'b0;
        wait_idle();
        bus.distance_mm = 12'($urandom_range(1, 450));
        pulse(15);
        wait_idle();

        check("pending_echo_expectations", exp_q.size(), 0);
        check("pending_trig_err_expectations", err_q.size(), 0);
        check("echo_count", n_echo, n_acc);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/hc_sr04_echo_emulator.md
Name: hc_sr04_echo_emulator

Overview:
- Synthesizable model of the HC-SR04 sensor side of the trig/echo interface.
- Answers a trig pulse from the ranging controller with an echo pulse whose width encodes a programmable distance.
- Used in loopback builds and benches in place of the real sensor.
- Sits between the ranging controller's trig output and its echo input; the target distance comes from a register or switch input.

Parameters:
- TRIG_MIN_CYC, 500, minimum synchronized trig high time in sys_clk cycles for a valid trigger (10 us at 50 MHz).
- BURST_DELAY_CYC, 25000, cycles from trig falling edge (synced) to echo rise; models the 8-pulse burst.
- CYC_PER_MM, 294, echo cycles per millimetre of distance (round trip at 340 m/s, 50 MHz).
- MAX_MM, 4000, largest in-range distance.
- TIMEOUT_CYC, 1900000, echo width for out-of-range or zero distance (38 ms).
- HOLDOFF_CYC, 500000, cycles after echo fall during which new triggers are ignored.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  asynchronous, active-high reset.
- trig  input  1  trigger from ranging controller, asynchronous to sys_clk.
- distance_mm  input  12  target distance in mm, sampled at valid trigger.
- echo  output  1  echo pulse to ranging controller.
- busy  output  1  high from valid trigger acceptance through end of holdoff.
- trig_err  output  1  one-cycle pulse when a trig pulse shorter than TRIG_MIN_CYC ends.

Behaviour:
- Reset, asynchronous and active-high:
  - echo=0, busy=0, trig_err=0.
  - FSM=IDLE, all counters=0, sync flops=0.
- trig passes through a 2-flop synchronizer (trig_s). Edges are detected on trig_s against its registered copy.
- States:
  - IDLE: on trig_s rise → TRIG_HI, high counter cleared to 1.
  - TRIG_HI: high counter increments each cycle trig_s=1, saturating at TRIG_MIN_CYC. On trig_s fall:
    - counter >= TRIG_MIN_CYC: latch distance_mm, busy=1 on that edge, → DELAY.
    - otherwise: trig_err=1 for exactly one cycle, → IDLE.
  - DELAY: count BURST_DELAY_CYC cycles, then → ECHO with echo=1 on the following edge.
  - ECHO: echo held high for exactly W cycles, then echo=0, → HOLDOFF.
    - W = latched_mm * CYC_PER_MM, computed in a 32-bit unsigned counter.
    - If latched_mm==0 or latched_mm>MAX_MM, W = TIMEOUT_CYC.
  - HOLDOFF: count HOLDOFF_CYC cycles, then busy=0, → IDLE.
- trig activity in DELAY, ECHO or HOLDOFF is ignored: no restart, no trig_err, distance not re-latched.
- A trig already high when HOLDOFF ends is not treated as a rise. A full low→high transition in IDLE is required.
- distance_mm changes after latching do not affect the current echo.
- Reset asserted mid-operation: echo drops immediately (asynchronously), FSM returns to IDLE. No pulse completes after release.
- Latency: trig pin fall → echo rise = 2 (sync) + 1 (edge) + BURST_DELAY_CYC + 1 cycles; the bench checks this exact value.
- echo and busy are registered outputs and are glitch-free.

Test Plan:
All scenarios use TRIG_MIN_CYC=10, BURST_DELAY_CYC=20, CYC_PER_MM=2, MAX_MM=400, TIMEOUT_CYC=1000, HOLDOFF_CYC=30.
- Valid trigger: distance_mm=100, trig high 15 cycles → echo rises exactly BURST_DELAY_CYC+4 cycles after trig fall and is high exactly 200 cycles. busy falls 30 cycles after echo fall. trig_err stays 0.
- Short trigger: trig high 5 cycles → trig_err one-cycle pulse, echo stays 0, busy stays 0. A following 12-cycle trig produces a normal echo.
- Out-of-range distance: distance_mm=401, then distance_mm=0 → echo width 1000 cycles each. distance_mm=400 → width 800.
- Retrigger while busy: second 15-cycle trig issued during ECHO and during HOLDOFF, with distance_mm changed to 50 in between → single echo of 200 cycles. No trig_err. No second echo.
- Reset mid-echo: assert sys_rst 50 cycles into echo → echo=0 and busy=0 within the same cycle. After release, no echo occurs without a new trig.
- Randomized trig: random trig toggles with 0–130 ns gaps for 20 edges, then a clean 15-cycle trig → echo width matches the latched distance, and busy always drops before the next accepted trigger.
